cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Two-master, one-slave arbiter that sits directly below the CPU core's instruction-side and data-side memory ports and presents a single request/response memory port to the memory system. It accepts SRAM-like split transactions (request handshake with `addr_ok`, response handshake with `data_ok`) from the fetch path and the load/store path. It serialises them with round-robin priority and keeps one transaction outstanding at a time. It routes each response back to the master that issued it.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req`  in  1  instruction-side request; held until `inst_addr_ok`.
- `inst_wr`  in  1  write flag (normally 0).
- `inst_size`  in  2  0=byte, 1=half, 2=word.
- `inst_addr`  in  ADDR_W  request address.
- `inst_wdata`  in  DATA_W  write data.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  response for the inst transaction this cycle.
- `inst_rdata`  out  DATA_W  read data, valid with `inst_data_ok`.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: the same set of signals for the data side.
- `mem_req`  out  1  slave request.
- `mem_wr`  out  1  slave write flag.
- `mem_size`  out  2  slave size.
- `mem_addr`  out  ADDR_W  slave address.
- `mem_wdata`  out  DATA_W  slave write data.
- `mem_addr_ok`  in  1  slave accepted the request.
- `mem_data_ok`  in  1  slave response (reads and writes).
- `mem_rdata`  in  DATA_W  slave read data.

## Operation
- FSM states:
  - IDLE: no transaction held.
  - ADDR: the latched request is driven to the slave and waits for `mem_addr_ok`.
  - DATA: the bridge waits for `mem_data_ok`.
- IDLE behaviour:
  - If exactly one master has `*_req`=1, grant it.
  - If both have `*_req`=1, grant the master that is not `last_grant`.
  - The granted master's `*_addr_ok`=1 combinationally in that cycle.
  - At the clock edge: latch that master's wr, size, addr and wdata; set `owner` and `last_grant` to the granted master; go to ADDR.
- ADDR: `mem_req`=1 with the latched fields. If `mem_addr_ok`=1, go to DATA; otherwise hold.
- DATA: when `mem_data_ok`=1:
  - `owner`'s `*_data_ok`=1 and `*_rdata`=`mem_rdata` combinationally in the same cycle;
  - go to IDLE.
- Write transactions also complete with `*_data_ok`. `*_rdata` is don't-care for writes.
- `*_addr_ok` is never asserted outside IDLE. The non-owner's `*_data_ok` is always 0.
- `mem_data_ok` seen in IDLE or ADDR is a protocol violation. It is ignored and no output pulses.
- No address or size decoding. Fields pass through unchanged.

## Timing
- Reset values: state=IDLE, `last_grant`=inst (so data wins the first tie), `owner`=inst, latched fields all 0.
- Reset output values: `mem_req`=0, all `*_addr_ok`=0, all `*_data_ok`=0; `mem_*` fields and `*_rdata` are 0.
  - `*_rdata` is gated to 0 when its `*_data_ok`=0.
- Request path: master `req` in cycle N (IDLE) → `addr_ok` in N → `mem_req` first high in N+1.
- Response path: `mem_data_ok` in cycle M → master `data_ok` in M; a new grant is possible at the earliest in M+1.
- Minimum back-to-back transaction period: 3 cycles (grant, slave address accept, slave response), with zero-wait slave handshakes.
- `mem_addr_ok` and `mem_data_ok` in the same cycle while in ADDR: only `addr_ok` is honoured. The slave must not do this.
- A master dropping `req` before `addr_ok` is legal and causes no grant.
- Reset asserted mid-transaction: the FSM returns immediately to IDLE and all outputs go to their reset values.
  - The in-flight transaction is abandoned.
  - A late `mem_data_ok` after reset is ignored, because the FSM is in IDLE.

## Test plan
- Single inst read:
  - Stimulus: `inst_req`=1, addr 0xBFC00000, size 2; slave gives `addr_ok` in cycle 1 and `data_ok` in cycle 3 with rdata 0x3C080001.
  - Required: `inst_addr_ok` in cycle 0; `mem_addr`=0xBFC00000 in cycles 1–2; `inst_data_ok`=1 with `inst_rdata`=0x3C080001 in cycle 3; `data_data_ok`=0 throughout.
- Simultaneous first requests:
  - Stimulus: inst and data both request in cycle 0 after reset.
  - Required: data is granted first; inst is granted in the first IDLE cycle after data's `data_ok`; `last_grant` alternates.
- Data byte write:
  - Stimulus: wr=1, size 0, addr 0x80001003, wdata 0x000000AB.
  - Required: `mem_wr`=1, `mem_size`=0 and the address/data passed through unchanged; `data_data_ok` on `mem_data_ok`.
- Slave stalls:
  - Stimulus: `mem_addr_ok` held low for 5 cycles, then `mem_data_ok` low for 4 cycles.
  - Required: `mem_req` and the fields stay stable across the stall; no new `addr_ok` to either master.
- Reset in DATA state:
  - Stimulus: `reset` pulsed while in DATA, then `mem_data_ok`=1 one cycle after release.
  - Required: all outputs 0; no `*_data_ok` pulse.
- Stray response:
  - Stimulus: `mem_data_ok`=1 while in IDLE.
  - Required: no master `data_ok`; state unchanged.

Source files
------------

// File: rtl/cpu_mem_arbiter_if.sv
// SRAM-like split-transaction port: request accepted with addr_ok, response returned with data_ok.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter merging the CPU instruction and data SRAM-like ports onto one memory port,
// with a single transaction outstanding at a time.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_arbiter_if.slave  inst_bus,
    cpu_mem_arbiter_if.slave  data_bus,
    cpu_mem_arbiter_if.master mem_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        M_INST = 1'b0,
        M_DATA = 1'b1
    } master_e;

    state_e            state_q, state_d;
    master_e           owner_q, owner_d;
    master_e           last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic grant_inst;
    logic grant_data;
    logic resp_fire;
    logic inst_done;
    logic data_done;

    // On a tie the master that did not win last time is granted; reset blocks any grant.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == ST_IDLE && !reset) begin
            if (inst_bus.req && data_bus.req) begin
                if (last_grant_q == M_INST) begin
                    grant_data = 1'b1;
                end else begin
                    grant_inst = 1'b1;
                end
            end else begin
                grant_inst = inst_bus.req;
                grant_data = data_bus.req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d      = ST_ADDR;
                    owner_d      = M_DATA;
                    last_grant_d = M_DATA;
                    wr_d         = data_bus.wr;
                    size_d       = data_bus.size;
                    addr_d       = data_bus.addr;
                    wdata_d      = data_bus.wdata;
                end else if (grant_inst) begin
                    state_d      = ST_ADDR;
                    owner_d      = M_INST;
                    last_grant_d = M_INST;
                    wr_d         = inst_bus.wr;
                    size_d       = inst_bus.size;
                    addr_d       = inst_bus.addr;
                    wdata_d      = inst_bus.wdata;
                end
            end
            // A response arriving together with addr_ok is deliberately not honoured here.
            ST_ADDR: begin
                if (mem_bus.addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_bus.data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= M_INST;
            last_grant_q <= M_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Stray responses outside DATA never reach a master; rdata is zero unless data_ok is high.
    always_comb begin
        resp_fire = (state_q == ST_DATA) && mem_bus.data_ok && !reset;
        inst_done = resp_fire && (owner_q == M_INST);
        data_done = resp_fire && (owner_q == M_DATA);
    end

    assign inst_bus.addr_ok = grant_inst;
    assign inst_bus.data_ok = inst_done;
    assign inst_bus.rdata   = inst_done ? mem_bus.rdata : '0;

    assign data_bus.addr_ok = grant_data;
    assign data_bus.data_ok = data_done;
    assign data_bus.rdata   = data_done ? mem_bus.rdata : '0;

    assign mem_bus.req   = (state_q == ST_ADDR);
    assign mem_bus.wr    = wr_q;
    assign mem_bus.size  = size_q;
    assign mem_bus.addr  = addr_q;
    assign mem_bus.wdata = wdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by a randomized run
// compared against a transaction-level reference model.
module tb_cpu_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) instBus ();
    cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dataBus ();
    cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) memBus ();

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .inst_bus (instBus),
        .data_bus (dataBus),
        .mem_bus  (memBus)
    );

    // Handshake snapshot: {inst addr_ok, inst data_ok, data addr_ok, data data_ok, mem req}.
    function automatic logic [4:0] ctrl();
        return {instBus.addr_ok, instBus.data_ok, dataBus.addr_ok, dataBus.data_ok, memBus.req};
    endfunction

    function automatic logic [66:0] memFields();
        return {memBus.wr, memBus.size, memBus.addr, memBus.wdata};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        instBus.req = 1'b0; instBus.wr = 1'b0; instBus.size = 2'd0; instBus.addr = '0; instBus.wdata = '0;
        dataBus.req = 1'b0; dataBus.wr = 1'b0; dataBus.size = 2'd0; dataBus.addr = '0; dataBus.wdata = '0;
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b0; memBus.rdata = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_ctrl got %b want 00000", ctrl()); end
        vectors++; if (memFields() !== 67'd0) begin miscompares++; $display("[TB] FAIL reset_mem_fields got %h want 0", memFields()); end
        vectors++; if ({instBus.rdata, dataBus.rdata} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_rdata got %h want 0", {instBus.rdata, dataBus.rdata}); end
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_release_ctrl got %b want 00000", ctrl()); end
        nextCycle();
    endtask

    task automatic test_single_inst_read();
        instBus.req = 1'b1; instBus.wr = 1'b0; instBus.size = 2'd2; instBus.addr = 32'hBFC00000;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b10000) begin miscompares++; $display("[TB] FAIL single_c0_ctrl got %b want 10000", ctrl()); end
        nextCycle();
        instBus.req = 1'b0; instBus.addr = $urandom; instBus.size = 2'd0;
        memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00001) begin miscompares++; $display("[TB] FAIL single_c1_ctrl got %b want 00001", ctrl()); end
        vectors++; if ({memBus.wr, memBus.size, memBus.addr} !== {1'b0, 2'd2, 32'hBFC00000}) begin miscompares++; $display("[TB] FAIL single_c1_fields got %h want %h", {memBus.wr, memBus.size, memBus.addr}, {1'b0, 2'd2, 32'hBFC00000}); end
        nextCycle();
        memBus.addr_ok = 1'b0;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00000) begin miscompares++; $display("[TB] FAIL single_c2_ctrl got %b want 00000", ctrl()); end
        vectors++; if (memBus.addr !== 32'hBFC00000) begin miscompares++; $display("[TB] FAIL single_c2_addr got %h want bfc00000", memBus.addr); end
        nextCycle();
        memBus.data_ok = 1'b1; memBus.rdata = 32'h3C080001;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b01000) begin miscompares++; $display("[TB] FAIL single_c3_ctrl got %b want 01000", ctrl()); end
        vectors++; if (instBus.rdata !== 32'h3C080001) begin miscompares++; $display("[TB] FAIL single_c3_rdata got %h want 3c080001", instBus.rdata); end
        vectors++; if (dataBus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL single_c3_data_rdata got %h want 0", dataBus.rdata); end
        nextCycle();
        memBus.data_ok = 1'b0;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00000) begin miscompares++; $display("[TB] FAIL single_c4_ctrl got %b want 00000", ctrl()); end
        nextCycle();
    endtask

    task automatic test_simultaneous();
        test_reset();
        instBus.req = 1'b1; instBus.size = 2'd2; instBus.addr = 32'h00001000;
        dataBus.req = 1'b1; dataBus.size = 2'd2; dataBus.addr = 32'h00002000;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00100) begin miscompares++; $display("[TB] FAIL tie1_grant got %b want 00100", ctrl()); end
        nextCycle();
        dataBus.req = 1'b0; memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if ({ctrl(), memBus.addr} !== {5'b00001, 32'h00002000}) begin miscompares++; $display("[TB] FAIL tie1_addr got %h want %h", {ctrl(), memBus.addr}, {5'b00001, 32'h00002000}); end
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1; memBus.rdata = 32'h11112222;
        @(negedge clk);
        vectors++; if ({ctrl(), dataBus.rdata} !== {5'b00010, 32'h11112222}) begin miscompares++; $display("[TB] FAIL tie1_resp got %h want %h", {ctrl(), dataBus.rdata}, {5'b00010, 32'h11112222}); end
        nextCycle();
        memBus.data_ok = 1'b0; dataBus.req = 1'b1; dataBus.addr = 32'h00003000;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b10000) begin miscompares++; $display("[TB] FAIL tie2_grant got %b want 10000", ctrl()); end
        nextCycle();
        instBus.req = 1'b0; memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if ({ctrl(), memBus.addr} !== {5'b00001, 32'h00001000}) begin miscompares++; $display("[TB] FAIL tie2_addr got %h want %h", {ctrl(), memBus.addr}, {5'b00001, 32'h00001000}); end
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1; memBus.rdata = 32'h33334444;
        @(negedge clk);
        vectors++; if ({ctrl(), instBus.rdata} !== {5'b01000, 32'h33334444}) begin miscompares++; $display("[TB] FAIL tie2_resp got %h want %h", {ctrl(), instBus.rdata}, {5'b01000, 32'h33334444}); end
        nextCycle();
        memBus.data_ok = 1'b0;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00100) begin miscompares++; $display("[TB] FAIL tie3_grant got %b want 00100", ctrl()); end
        nextCycle();
        dataBus.req = 1'b0; memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if ({ctrl(), memBus.addr} !== {5'b00001, 32'h00003000}) begin miscompares++; $display("[TB] FAIL tie3_addr got %h want %h", {ctrl(), memBus.addr}, {5'b00001, 32'h00003000}); end
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00010) begin miscompares++; $display("[TB] FAIL tie3_resp got %b want 00010", ctrl()); end
        nextCycle();
        idleInputs();
    endtask

    task automatic test_data_byte_write();
        dataBus.req = 1'b1; dataBus.wr = 1'b1; dataBus.size = 2'd0; dataBus.addr = 32'h80001003; dataBus.wdata = 32'h000000AB;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00100) begin miscompares++; $display("[TB] FAIL bytewr_grant got %b want 00100", ctrl()); end
        nextCycle();
        dataBus.req = 1'b0; dataBus.wr = 1'b0; dataBus.wdata = $urandom; memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if (memFields() !== {1'b1, 2'd0, 32'h80001003, 32'h000000AB}) begin miscompares++; $display("[TB] FAIL bytewr_fields got %h want %h", memFields(), {1'b1, 2'd0, 32'h80001003, 32'h000000AB}); end
        vectors++; if (ctrl() !== 5'b00001) begin miscompares++; $display("[TB] FAIL bytewr_req got %b want 00001", ctrl()); end
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1; memBus.rdata = $urandom;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00010) begin miscompares++; $display("[TB] FAIL bytewr_resp got %b want 00010", ctrl()); end
        nextCycle();
        idleInputs();
    endtask

    task automatic test_slave_stall();
        logic [66:0] held;
        held = {1'b0, 2'd1, 32'hA0000040, 32'h0};
        instBus.req = 1'b1; instBus.wr = 1'b0; instBus.size = 2'd1; instBus.addr = 32'hA0000040; instBus.wdata = '0;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b10000) begin miscompares++; $display("[TB] FAIL stall_grant got %b want 10000", ctrl()); end
        nextCycle();
        dataBus.req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instBus.addr = $urandom; dataBus.addr = $urandom; instBus.wdata = $urandom;
            @(negedge clk);
            vectors++; if ({ctrl(), memFields()} !== {5'b00001, held}) begin miscompares++; $display("[TB] FAIL stall_addr_wait%0d got %h want %h", i, {ctrl(), memFields()}, {5'b00001, held}); end
            nextCycle();
        end
        memBus.addr_ok = 1'b1;
        @(negedge clk);
        vectors++; if ({ctrl(), memFields()} !== {5'b00001, held}) begin miscompares++; $display("[TB] FAIL stall_accept got %h want %h", {ctrl(), memFields()}, {5'b00001, held}); end
        nextCycle();
        memBus.addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if ({ctrl(), memFields()} !== {5'b00000, held}) begin miscompares++; $display("[TB] FAIL stall_data_wait%0d got %h want %h", i, {ctrl(), memFields()}, {5'b00000, held}); end
            nextCycle();
        end
        memBus.data_ok = 1'b1; memBus.rdata = 32'hCAFE0001;
        @(negedge clk);
        vectors++; if ({ctrl(), instBus.rdata} !== {5'b01000, 32'hCAFE0001}) begin miscompares++; $display("[TB] FAIL stall_resp got %h want %h", {ctrl(), instBus.rdata}, {5'b01000, 32'hCAFE0001}); end
        nextCycle();
        idleInputs();
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00000) begin miscompares++; $display("[TB] FAIL stall_after got %b want 00000", ctrl()); end
        nextCycle();
    endtask

    task automatic test_reset_in_data();
        dataBus.req = 1'b1; dataBus.size = 2'd2; dataBus.addr = 32'h80000100; dataBus.wdata = 32'h55;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00100) begin miscompares++; $display("[TB] FAIL rstdata_grant got %b want 00100", ctrl()); end
        nextCycle();
        dataBus.req = 1'b0; memBus.addr_ok = 1'b1;
        nextCycle();
        memBus.addr_ok = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if ({ctrl(), memFields()} !== 72'd0) begin miscompares++; $display("[TB] FAIL rstdata_outputs got %h want 0", {ctrl(), memFields()}); end
        nextCycle();
        reset = 1'b0;
        memBus.data_ok = 1'b1; memBus.rdata = 32'hDEAD0000;
        @(negedge clk);
        vectors++; if ({ctrl(), instBus.rdata, dataBus.rdata} !== 69'd0) begin miscompares++; $display("[TB] FAIL rstdata_late_resp got %h want 0", {ctrl(), instBus.rdata, dataBus.rdata}); end
        nextCycle();
        memBus.data_ok = 1'b0; instBus.req = 1'b1; dataBus.req = 1'b1;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00100) begin miscompares++; $display("[TB] FAIL rstdata_tie got %b want 00100", ctrl()); end
        nextCycle();
        instBus.req = 1'b0; dataBus.req = 1'b0; memBus.addr_ok = 1'b1;
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1;
        nextCycle();
        idleInputs();
    endtask

    task automatic test_stray_response();
        memBus.data_ok = 1'b1; memBus.rdata = $urandom;
        @(negedge clk);
        vectors++; if ({ctrl(), instBus.rdata, dataBus.rdata} !== 69'd0) begin miscompares++; $display("[TB] FAIL stray_idle got %h want 0", {ctrl(), instBus.rdata, dataBus.rdata}); end
        nextCycle();
        memBus.data_ok = 1'b0; instBus.req = 1'b1; instBus.addr = 32'h00000040;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b10000) begin miscompares++; $display("[TB] FAIL stray_then_grant got %b want 10000", ctrl()); end
        nextCycle();
        instBus.req = 1'b0; memBus.data_ok = 1'b1;
        @(negedge clk);
        vectors++; if (ctrl() !== 5'b00001) begin miscompares++; $display("[TB] FAIL stray_in_addr got %b want 00001", ctrl()); end
        nextCycle();
        memBus.data_ok = 1'b0; memBus.addr_ok = 1'b1;
        nextCycle();
        memBus.addr_ok = 1'b0; memBus.data_ok = 1'b1; memBus.rdata = 32'h12345678;
        @(negedge clk);
        vectors++; if ({ctrl(), instBus.rdata} !== {5'b01000, 32'h12345678}) begin miscompares++; $display("[TB] FAIL stray_real_resp got %h want %h", {ctrl(), instBus.rdata}, {5'b01000, 32'h12345678}); end
        nextCycle();
        idleInputs();
    endtask

    // Reference model: at most one transaction in flight, tracked as owner plus an "accepted by slave" flag.
    task automatic test_random();
        bit            busy = 1'b0;
        bit            accepted = 1'b0;
        int            who = 0;
        int            lastWinner = 0;
        logic [66:0]   held = '0;
        int            winner;
        logic [135:0]  expected;
        logic [135:0]  actual;
        logic          respI;
        logic          respD;
        test_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instBus.req = ($urandom_range(0, 9) < 6); instBus.wr = 1'($urandom_range(0, 1)); instBus.size = 2'($urandom_range(0, 3));
            instBus.addr = $urandom; instBus.wdata = $urandom;
            dataBus.req = ($urandom_range(0, 9) < 6); dataBus.wr = 1'($urandom_range(0, 1)); dataBus.size = 2'($urandom_range(0, 3));
            dataBus.addr = $urandom; dataBus.wdata = $urandom;
            memBus.addr_ok = 1'($urandom_range(0, 1)); memBus.data_ok = ($urandom_range(0, 9) < 4); memBus.rdata = $urandom;
            winner = -1;
            if (!busy) begin
                if (instBus.req && dataBus.req) winner = (lastWinner == 0) ? 1 : 0;
                else if (instBus.req) winner = 0;
                else if (dataBus.req) winner = 1;
            end
            respI = busy && accepted && memBus.data_ok && (who == 0);
            respD = busy && accepted && memBus.data_ok && (who == 1);
            expected = {winner == 0, respI, respI ? memBus.rdata : 32'h0,
                        winner == 1, respD, respD ? memBus.rdata : 32'h0,
                        busy && !accepted, held};
            @(negedge clk);
            actual = {instBus.addr_ok, instBus.data_ok, instBus.rdata,
                      dataBus.addr_ok, dataBus.data_ok, dataBus.rdata,
                      memBus.req, memFields()};
            vectors++; if (actual !== expected) begin miscompares++; $display("[TB] FAIL random_cycle%0d got %h want %h", cyc, actual, expected); end
            if (winner == 0) begin
                busy = 1'b1; accepted = 1'b0; who = 0; lastWinner = 0;
                held = {instBus.wr, instBus.size, instBus.addr, instBus.wdata};
            end else if (winner == 1) begin
                busy = 1'b1; accepted = 1'b0; who = 1; lastWinner = 1;
                held = {dataBus.wr, dataBus.size, dataBus.addr, dataBus.wdata};
            end else if (busy && !accepted && memBus.addr_ok) begin
                accepted = 1'b1;
            end else if (busy && accepted && memBus.data_ok) begin
                busy = 1'b0;
            end
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_single_inst_read();
        test_simultaneous();
        test_data_byte_write();
        test_slave_stall();
        test_reset_in_data();
        test_stray_response();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
